// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and helpers for the multi-cycle ALU.
package alu_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StMul  = 2'd1,
      StDone = 2'd2
   } alu_state_e;

   typedef enum logic [4:0] {
      OpAdd   = 5'd1,
      OpSub   = 5'd2,
      OpAddu  = 5'd3,
      OpSubu  = 5'd4,
      OpAddi  = 5'd5,
      OpAddiu = 5'd6,
      OpAnd   = 5'd7,
      OpOr    = 5'd8,
      OpAndi  = 5'd9,
      OpOri   = 5'd10,
      OpSll   = 5'd11,
      OpSrl   = 5'd12,
      OpSra   = 5'd13,
      OpMul   = 5'd14,
      OpSlt   = 5'd24,
      OpSgt   = 5'd25,
      OpSltu  = 5'd26,
      OpSgtu  = 5'd27
   } alu_op_e;

   // Number of low instr_ID bits that carry the opcode; anything above must be zero.
   localparam int unsigned OpBits = 5;

   // Two's-complement overflow of a + b given the sign bits of a, b and the sum.
   function automatic logic add_ovf(logic a_msb, logic b_msb, logic r_msb);
      return (a_msb == b_msb) && (r_msb != a_msb);
   endfunction

endpackage

// File: rtl/alu_multicycle_if.sv
// Issue/result handshake bundle between an ALU client (master) and the ALU (slave).
interface alu_multicycle_if #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned ID_W  = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [ID_W-1:0]  instr_ID;
   logic [WIDTH-1:0] rs;
   logic [WIDTH-1:0] rt;
   logic [WIDTH-1:0] initial_pc;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] rd;
   logic [WIDTH-1:0] pc;
   logic             ovf;
   logic             illegal;

   modport master (
      output in_valid, instr_ID, rs, rt, initial_pc, out_ready,
      input  in_ready, out_valid, rd, pc, ovf, illegal
   );

   modport slave (
      input  in_valid, instr_ID, rs, rt, initial_pc, out_ready,
      output in_ready, out_valid, rd, pc, ovf, illegal
   );
endinterface

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH cycles per operation.
module alu_mul_iter #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic             busy_q, busy_d;

   always_comb begin
      acc_d    = acc_q;
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      cnt_d    = cnt_q;
      busy_d   = busy_q;
      if (start) begin
         acc_d    = '0;
         mcand_d  = a;
         mplier_d = b;
         cnt_d    = CntW'(WIDTH);
         busy_d   = 1'b1;
      end else if (busy_q && (cnt_q != '0)) begin
         if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
         end
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q - CntW'(1);
      end else if (busy_q) begin
         // Result is taken in the cycle done is high.
         busy_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         cnt_q    <= '0;
         busy_q   <= 1'b0;
      end else begin
         acc_q    <= acc_d;
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         cnt_q    <= cnt_d;
         busy_q   <= busy_d;
      end
   end

   assign busy    = busy_q;
   assign done    = busy_q && (cnt_q == '0);
   assign product = acc_q;

endmodule

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle ops complete on acceptance, mul iterates WIDTH steps.
module alu_multicycle
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned ID_W    = 32,
   parameter int unsigned PC_STEP = 4
) (
   input logic              clk,
   input logic              rst,
   alu_multicycle_if.slave  bus
);
   localparam int unsigned ShW = $clog2(WIDTH);

   alu_state_e       state_q, state_d;
   logic [WIDTH-1:0] rd_q, rd_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic             ovf_q, ovf_d;
   logic             ill_q, ill_d;

   logic [ID_W-1:0]  op_id;
   logic             op_hi_zero;
   alu_op_e          op;
   logic [WIDTH-1:0] rs, rt, sum, diff;
   logic [ShW-1:0]   shamt;
   logic             lt_s, gt_s, lt_u, gt_u;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ovf, alu_ill, is_mul;

   logic             mul_start, mul_busy, mul_done;
   logic [WIDTH-1:0] mul_product;

   assign op_id      = bus.instr_ID;
   assign op_hi_zero = (op_id >> OpBits) == '0;
   assign op         = alu_op_e'(op_id[OpBits-1:0]);
   assign rs         = bus.rs;
   assign rt         = bus.rt;
   assign sum        = rs + rt;
   assign diff       = rs - rt;
   assign shamt      = rt[ShW-1:0];
   assign lt_s       = $signed(rs) < $signed(rt);
   assign gt_s       = $signed(rt) < $signed(rs);
   assign lt_u       = rs < rt;
   assign gt_u       = rt < rs;

   always_comb begin
      alu_res = '0;
      alu_ovf = 1'b0;
      alu_ill = 1'b0;
      is_mul  = 1'b0;
      if (!op_hi_zero) begin
         alu_ill = 1'b1;
      end else begin
         unique case (op)
            OpAdd, OpAddi: begin
               alu_res = sum;
               alu_ovf = add_ovf(rs[WIDTH-1], rt[WIDTH-1], sum[WIDTH-1]);
            end
            OpSub: begin
               alu_res = diff;
               alu_ovf = add_ovf(rs[WIDTH-1], ~rt[WIDTH-1], diff[WIDTH-1]);
            end
            OpAddu, OpAddiu: alu_res = sum;
            OpSubu:          alu_res = diff;
            OpAnd, OpAndi:   alu_res = rs & rt;
            OpOr, OpOri:     alu_res = rs | rt;
            OpSll:           alu_res = rs << shamt;
            OpSrl:           alu_res = rs >> shamt;
            OpSra:           alu_res = WIDTH'($signed(rs) >>> shamt);
            OpMul:           is_mul  = 1'b1;
            OpSlt:           alu_res = {{(WIDTH-1){1'b0}}, lt_s};
            OpSgt:           alu_res = {{(WIDTH-1){1'b0}}, gt_s};
            OpSltu:          alu_res = {{(WIDTH-1){1'b0}}, lt_u};
            OpSgtu:          alu_res = {{(WIDTH-1){1'b0}}, gt_u};
            default:         alu_ill = 1'b1;
         endcase
      end
   end

   alu_mul_iter #(
      .WIDTH (WIDTH)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (mul_start),
      .a       (rs),
      .b       (rt),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Outputs are registered at acceptance so they stay frozen through DONE.
   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      pc_d      = pc_q;
      ovf_d     = ovf_q;
      ill_d     = ill_q;
      mul_start = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               rd_d  = alu_res;
               pc_d  = bus.initial_pc + WIDTH'(PC_STEP);
               ovf_d = alu_ovf;
               ill_d = alu_ill;
               if (is_mul) begin
                  mul_start = 1'b1;
                  state_d   = StMul;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StMul: begin
            if (mul_done) begin
               rd_d    = mul_product;
               state_d = StDone;
            end else if (!mul_busy) begin
               state_d = StIdle;
            end
         end
         StDone: begin
            if (bus.out_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         rd_q    <= '0;
         pc_q    <= '0;
         ovf_q   <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         pc_q    <= pc_d;
         ovf_q   <= ovf_d;
         ill_q   <= ill_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.rd        = rd_q;
   assign bus.pc        = pc_q;
   assign bus.ovf       = ovf_q;
   assign bus.illegal   = ill_q;

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning operand/result/PC width (>= 8, power of 2).
REQ-002 The block SHALL have parameter ID_W, default 32, meaning instruction-ID width.
REQ-003 The block SHALL have parameter PC_STEP, default 4, meaning PC increment per instruction.
REQ-004 The block SHALL have one clock and a synchronous, active-high reset.
REQ-005 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation offered.
- in_ready  out  1  operation accepted when in_valid && in_ready at a clk edge.
- instr_ID  in  ID_W  operation code.
- rs  in  WIDTH  operand A.
- rt  in  WIDTH  operand B or immediate.
- initial_pc  in  WIDTH  PC of the instruction.
- out_valid  out  1  result held valid.
- out_ready  in  1  consumer takes result.
- rd  out  WIDTH  result.
- pc  out  WIDTH  next PC.
- ovf  out  1  signed overflow.
- illegal  out  1  unknown instr_ID.

Function
REQ-006 The block SHALL use three states: IDLE, MUL and DONE.
REQ-007 in_ready SHALL equal (state==IDLE); accepting captures instr_ID, rs, rt and initial_pc.
REQ-008 Opcodes SHALL be: 1 add, 2 sub, 3 addu, 4 subu, 5 addi, 6 addiu, 7 and, 8 or, 9 andi, 10 ori, 11 sll, 12 srl, 13 sra, 14 mul, 24 slt (signed rs<rt), 25 sgt (signed rs>rt), 26 sltu, 27 sgtu.
REQ-009 For non-mul opcodes, acceptance at edge N SHALL go IDLE->DONE, with out_valid high from edge N (latency 1).
REQ-010 Opcode 14 SHALL go IDLE->MUL and perform one shift-add step per cycle for WIDTH cycles, then MUL->DONE, with out_valid high from edge N+WIDTH+1 and rd = low WIDTH bits of rs*rt.
REQ-011 In DONE, rd, pc, ovf and illegal SHALL hold stable until out_ready; an out_valid && out_ready edge SHALL go DONE->IDLE.
REQ-012 pc SHALL equal initial_pc+PC_STEP modulo 2^WIDTH, wrapping silently.
REQ-013 Arithmetic SHALL be modulo 2^WIDTH.
REQ-014 ovf SHALL be 1 only for opcodes 1, 2 and 5 on two's-complement overflow; it SHALL be 0 for all other opcodes, including 3, 4 and 6.
REQ-015 Shift amount SHALL be rt[log2(WIDTH)-1:0]; upper rt bits SHALL be ignored.
REQ-016 sra SHALL replicate rs[WIDTH-1].
REQ-017 Compare results SHALL be zero-extended 0 or 1.
REQ-018 An unlisted opcode SHALL take the 1-cycle path with rd=0, ovf=0, illegal=1, and pc still = initial_pc+PC_STEP.
REQ-019 Input changes while not IDLE SHALL be ignored.
REQ-020 in_valid in DONE SHALL not be accepted until the state returns to IDLE, giving a minimum 2-cycle issue interval.

Reset
REQ-021 rst SHALL override all activity, including mid-MUL or DONE, and force state IDLE.
REQ-022 On rst, out_valid=0, rd=0, pc=0, ovf=0, illegal=0 and the multiplier counter = 0.
REQ-023 in_ready SHALL be 1 in the cycle after reset deasserts.
REQ-024 A result discarded by reset SHALL never appear.

Structure
REQ-025 Opcode constants and the state encoding SHALL live in shared package alu_pkg.
REQ-026 The iterative multiplier SHALL be sub-module alu_mul_iter (parameter WIDTH; start, a, b in; busy, done, product out), with its own cycle counter.
REQ-027 Opcode decode and result muxing SHALL stay in alu_multicycle.

Verification
REQ-028 The bench SHALL check add, WIDTH=32: rs=0x7FFFFFFF, rt=1, id=1, pc=0x100 -> rd=0x80000000, ovf=1, pc=0x104, out_valid 1 cycle after accept.
REQ-029 The bench SHALL check mul: rs=0xFFFF, rt=0x10001, id=14 -> rd=0xFFFFFFFF, out_valid exactly 33 cycles after accept, in_ready=0 throughout.
REQ-030 The bench SHALL check backpressure: after a sub result (rs=5, rt=7 -> rd=0xFFFFFFFE), hold out_ready=0 for 5 cycles -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle.
REQ-031 The bench SHALL check shifts and compares: sra rs=0x80000000, rt=0x21 -> 0xC0000000; slt rs=0xFFFFFFFF, rt=0 -> 1; sltu with the same operands -> 0.
REQ-032 The bench SHALL check an illegal opcode and PC wrap: id=99, pc=0xFFFFFFFC -> illegal=1, rd=0, pc=0.
REQ-033 The bench SHALL check reset mid-MUL: assert rst 10 cycles after mul accept -> out_valid stays 0, all outputs 0, in_ready=1 after release.
